// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: base opcodes, forwarding-select encodings and the
// register-usage records exchanged between decode and hazard logic.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Full register-usage view of one instruction (also the EX shadow slot).
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use1;
    logic       use2;
    logic       wr;
    logic       is_load;
  } reg_use_t;

  // Reduced shadow slot kept for MEM and WB.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } slot_t;

  // MEM has priority over WB because it carries the younger result.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input logic use_rs,
                                          input slot_t mem, input slot_t wb);
    fwd_pick = FWD_RF;
    if (use_rs && rs != 5'd0) begin
      if (mem.wr && mem.rd == rs)      fwd_pick = FWD_MEM;
      else if (wb.wr && wb.rd == rs)   fwd_pick = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Extracts source/destination register fields and their usage bits from an
// RV32 instruction; bubbles and unknown opcodes report no register usage.
module reg_use_decode
  import rv32_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [Width-1:0] inst,
  input  logic             valid,
  output reg_use_t         dec
);

  logic unused_bits;
  assign unused_bits = ^{inst[Width-1:25], inst[14:12]};

  always_comb begin
    dec     = '0;
    dec.rd  = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    if (valid) begin
      case (inst[6:0])
        OP_BRANCH: begin dec.use1 = 1'b1; dec.use2 = 1'b1; end
        OP_LOAD:   begin dec.use1 = 1'b1; dec.wr = 1'b1; dec.is_load = 1'b1; end
        OP_STORE:  begin dec.use1 = 1'b1; dec.use2 = 1'b1; end
        OP_IMM:    begin dec.use1 = 1'b1; dec.wr = 1'b1; end
        OP:        begin dec.use1 = 1'b1; dec.use2 = 1'b1; dec.wr = 1'b1; end
        OP_JAL:    dec.wr = 1'b1;
        OP_JALR:   begin dec.use1 = 1'b1; dec.wr = 1'b1; end
        OP_LUI:    dec.wr = 1'b1;
        OP_AUIPC:  dec.wr = 1'b1;
        default:   ;
      endcase
    end
    // x0 is hardwired, so writing it never creates a dependency.
    if (dec.rd == 5'd0) dec.wr = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows register usage of EX/MEM/WB and derives
// stall, flush, bubble, freeze and operand-forwarding controls.
module hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int Width = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] id_inst,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  reg_use_t         id_dec;
  reg_use_t         ex_reg, ex_next;
  slot_t            mem_reg, wb_reg;
  logic             load_use;
  logic [CNT_W-1:0] stall_count_reg;
  logic             unused_wb;

  reg_use_decode #(.Width(Width)) u_decode (
    .inst  (id_inst),
    .valid (id_valid),
    .dec   (id_dec)
  );

  assign unused_wb = wb_reg.is_load;

  assign load_use = ex_reg.is_load && ex_reg.wr &&
                    ((id_dec.use1 && id_dec.rs1 == ex_reg.rd) ||
                     (id_dec.use2 && id_dec.rs2 == ex_reg.rd));

  // Memory back-pressure outranks redirect, which outranks the load-use stall.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    if (dmem_busy) begin
      freeze   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    ex_next = id_dec;
    if (bubble_ex) ex_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      wb_reg  <= '0;
    end else if (!freeze) begin
      ex_reg  <= ex_next;
      mem_reg <= slot_t'{rd: ex_reg.rd, wr: ex_reg.wr, is_load: ex_reg.is_load};
      wb_reg  <= mem_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (stall_if && stall_count_reg != {CNT_W{1'b1}}) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign stall_count = stall_count_reg;

  // Operand 0 is rs1 (fwd_a), operand 1 is rs2 (fwd_b).
  logic [4:0] op_rs   [2];
  logic       op_use  [2];
  logic [1:0] fwd_sel [2];

  assign op_rs[0]  = ex_reg.rs1;
  assign op_rs[1]  = ex_reg.rs2;
  assign op_use[0] = ex_reg.use1;
  assign op_use[1] = ex_reg.use2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = fwd_pick(op_rs[gi], op_use[gi], mem_reg, wb_reg);
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding, x0, redirect, freeze,
// reset-during-stall and counter saturation (counter narrowed to 4 bits).
module tb_hazard_ctrl;
  import rv32_pkg::*;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  id_inst;
  logic          id_valid;
  logic          ex_redirect;
  logic          dmem_busy;
  logic          stall_if, stall_id, flush_id, bubble_ex, freeze;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.Width(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .ex_redirect (ex_redirect),
    .dmem_busy   (dmem_busy),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .bubble_ex   (bubble_ex),
    .freeze      (freeze),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_count (stall_count)
  );

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Order: stall_if, stall_id, flush_id, bubble_ex, freeze.
  task automatic ctrl_chk(input string tag, input logic [4:0] exp);
    chk({tag, ".ctrl"}, {27'd0, stall_if, stall_id, flush_id, bubble_ex, freeze}, {27'd0, exp});
    $display("step %s: ctrl=%b fwd_a=%b fwd_b=%b cnt=%0d", tag,
             {stall_if, stall_id, flush_id, bubble_ex, freeze}, fwd_a, fwd_b, stall_count);
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic [31:0] inst, input logic valid, input logic redir,
                       input logic busy);
    id_inst     = inst;
    id_valid    = valid;
    ex_redirect = redir;
    dmem_busy   = busy;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 3; i++) begin
      drive(32'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  logic [31:0] lw_x5, add_x6_x5_x2, addi_x5, add_x6_x5_x5, sub_x7, lw_x0, add_x6_x0_x0;

  initial begin
    lw_x5        = i_type(12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD);
    add_x6_x5_x2 = r_type(7'b0000000, 5'd2, 5'd5, 5'd6);
    addi_x5      = i_type(12'd7, 5'd0, 3'b000, 5'd5, OP_IMM);
    add_x6_x5_x5 = r_type(7'b0000000, 5'd5, 5'd5, 5'd6);
    sub_x7       = r_type(7'b0100000, 5'd0, 5'd5, 5'd7);
    lw_x0        = i_type(12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD);
    add_x6_x0_x0 = r_type(7'b0000000, 5'd0, 5'd0, 5'd6);

    rst = 1'b1; id_inst = '0; id_valid = 1'b0; ex_redirect = 1'b0; dmem_busy = 1'b0;
    do_reset();

    // Reset state
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    ctrl_chk("reset", 5'b00000);
    chk("reset.fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("reset.cnt", stall_count, 0);
    tick();

    // Load-use: lw x5 then add x6,x5,x2
    drive(lw_x5, 1'b1, 1'b0, 1'b0);
    ctrl_chk("lu.lw", 5'b00000);
    tick();
    drive(add_x6_x5_x2, 1'b1, 1'b0, 1'b0);
    ctrl_chk("lu.stall", 5'b11010);
    tick();
    drive(add_x6_x5_x2, 1'b1, 1'b0, 1'b0);
    ctrl_chk("lu.release", 5'b00000);
    chk("lu.cnt", stall_count, 1);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("lu.fwd_a", fwd_a, FWD_WB);
    chk("lu.fwd_b", fwd_b, FWD_RF);
    tick();
    drain();

    // ALU back-to-back forwarding
    drive(addi_x5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(add_x6_x5_x5, 1'b1, 1'b0, 1'b0);
    ctrl_chk("alu.nostall", 5'b00000);
    tick();
    drive(sub_x7, 1'b1, 1'b0, 1'b0);
    chk("alu.fwd", {fwd_a, fwd_b}, {FWD_MEM, FWD_MEM});
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("alu.sub_fwd", {fwd_a, fwd_b}, {FWD_WB, FWD_RF});
    tick();
    drain();

    // x0 never hazards
    drive(lw_x0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(add_x6_x0_x0, 1'b1, 1'b0, 1'b0);
    ctrl_chk("x0.nostall", 5'b00000);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("x0.fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("x0.cnt", stall_count, 1);
    tick();
    drain();

    // Redirect beats load-use
    drive(lw_x5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(add_x6_x5_x2, 1'b1, 1'b1, 1'b0);
    ctrl_chk("redir", 5'b00110);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("redir.cnt", stall_count, 1);
    tick();

    // Freeze for 3 cycles with addi x5 in MEM and add x6,x5,x5 in EX
    do_reset();
    drive(addi_x5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(add_x6_x5_x5, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(sub_x7, 1'b1, 1'b0, 1'b1);
      ctrl_chk($sformatf("frz%0d", i), 5'b11001);
      chk($sformatf("frz%0d.fwd_a", i), fwd_a, FWD_MEM);
      tick();
    end
    drive(sub_x7, 1'b1, 1'b0, 1'b0);
    ctrl_chk("frz.release", 5'b00000);
    chk("frz.cnt", stall_count, 3);
    chk("frz.fwd_a_held", fwd_a, FWD_MEM);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("frz.advanced", fwd_a, FWD_WB);
    tick();

    // Reset during a load-use stall
    do_reset();
    drive(lw_x5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(add_x6_x5_x2, 1'b1, 1'b0, 1'b0);
    ctrl_chk("rst.stall", 5'b11010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(add_x6_x5_x2, 1'b1, 1'b0, 1'b0);
    ctrl_chk("rst.after", 5'b00000);
    chk("rst.fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("rst.cnt", stall_count, 0);
    tick();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(32'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(32'd0, 1'b0, 1'b0, 1'b1);
    chk("sat.full", stall_count, 15);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("sat.hold", stall_count, 15);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It shadows the destination and source register fields of the instructions in EX, MEM and WB. From those it produces stall, flush and bubble controls for the IF/ID and ID/EX registers, plus forwarding selects for the EX operand muxes. It sits beside the ID stage and decodes the same opcode set used by the immediate generator.

## Interface
- Width, 32, instruction/data width.
- CNT_W, 32, width of the stall performance counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_inst  in  Width  instruction currently held in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction; 0 means bubble.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- dmem_busy  in  1  data memory has not completed the MEM-stage access.
- stall_if  out  1  hold the PC.
- stall_id  out  1  hold IF/ID.
- flush_id  out  1  clear IF/ID to a bubble.
- bubble_ex  out  1  load a bubble into ID/EX instead of ID contents.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a  out  2  EX rs1 source: 00 regfile, 01 WB, 10 MEM.
- fwd_b  out  2  EX rs2 source, same encoding as fwd_a.
- stall_count  out  CNT_W  saturating count of cycles with stall_if=1.

## Operation
- **ID decode** (opcode = id_inst[6:0]):
  - uses_rs1: B, LOAD, STORE, OP-IMM, OP, JALR.
  - uses_rs2: B, STORE, OP.
  - writes_rd: LOAD, OP-IMM, OP, JAL, JALR, LUI, AUIPC.
  - All usage bits are 0 when id_valid=0 or the opcode is unknown.
  - rd=0 forces writes_rd=0.
- **Shadow state**, one slot per stage (EX, MEM, WB). Each slot holds rd[4:0], wr, and is_load. The EX slot also holds rs1, rs2, use1 and use2.
- **Advance rule**, when freeze=0:
  - EX slot ← decoded ID fields, or cleared if bubble_ex=1.
  - MEM ← EX; WB ← MEM.
  - When freeze=1, all slots hold.
- **Priority**, evaluated combinationally each cycle:
  1. dmem_busy=1: freeze=stall_if=stall_id=1; flush_id=bubble_ex=0.
  2. ex_redirect=1: flush_id=bubble_ex=1; stalls 0.
  3. Load-use: EX.is_load and EX.wr and ((use_rs1 and rs1==EX.rd) or (use_rs2 and rs2==EX.rd)). Result: stall_if=stall_id=bubble_ex=1.
  4. Otherwise: all controls 0.
- **Forwarding** for each EX operand (use bit set, rs≠0):
  - MEM.wr and MEM.rd==rs → 10.
  - Else WB.wr and WB.rd==rs → 01.
  - Else 00.
  - MEM wins when both match. Selects are computed during freeze as well.
  - Loads in MEM are never forwarded from MEM: that case is blocked by the load-use stall and resolves via WB.
- **stall_count** increments when stall_if=1 and saturates at all-ones.

## Timing
- Reset (rst=1 at the edge): all slots cleared and stall_count=0.
- Output values with slots cleared: stall_if=stall_id=flush_id=bubble_ex=0, fwd_a=fwd_b=00. freeze and stall_if also track dmem_busy combinationally.
- Control outputs are combinational from the registered slots plus current inputs; there is zero-cycle latency inside the cycle.
- Load-use stall lasts exactly one cycle. After the bubble, the load sits in MEM and the dependent instruction's fwd selects WB on the following cycle.
- Redirect and load-use in the same cycle: redirect wins and no stall occurs.
- dmem_busy held for N cycles freezes for N cycles. A load-use condition pending underneath is re-evaluated after release.
- rst asserted mid-stall clears the slots; the next cycle is free of stalls.

## Structure
- **Shared package** `rv32_pkg`:
  - opcode constants: OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_IMM 0010011, OP 0110011, OP_JAL 1101111, OP_JALR 1100111, OP_LUI 0110111, OP_AUIPC 0010111.
  - FWD_RF/FWD_WB/FWD_MEM encodings.
- **Sub-module** `reg_use_decode`: combinational extraction of rs1/rs2/rd, use/write bits and is_load from an instruction. It is reusable by the ID stage.

## Test plan
- `lw x5,0(x1)` followed by `add x6,x5,x2` → one cycle with stall_if=stall_id=bubble_ex=1. The next cycle has fwd_a=01. stall_count=1.
- `addi x5,x0,7` followed by `add x6,x5,x5` → no stall; fwd_a=fwd_b=10. One instruction later, `sub x7,x5,x0` → fwd_a=01.
- `lw x0,0(x1)` followed by `add x6,x0,x0` → no stall; fwd 00 (x0 never hazards).
- Load-use pending with ex_redirect=1 in the same cycle → flush_id=bubble_ex=1, stall_if=0, stall_count unchanged.
- dmem_busy=1 for 3 cycles with `addi x5` in MEM → freeze for 3 cycles, fwd_a=10 held throughout, stall_count=3. Advancing resumes on the 4th cycle.
- rst asserted during a load-use stall → next cycle all outputs 0 and stall_count=0. Separately, force stall_count to all-ones and stall again → counter stays at all-ones.
